mez_ide_cycle: RTL and testbench
================================

Name: mez_ide_cycle

Overview:
- IDE PIO bus-cycle sequencer on the Wrap030 Mezzanine board; it sits downstream of the mezzanine address decode, which provides ideSel.
- Converts a 68030 asynchronous bus cycle into ATA PIO-mode-0 timed chip-select, IORD/IOWR strobes and buffer enable.
- Terminates the CPU cycle with sized DSACK, 16-bit or 8-bit according to IOCS16.

Parameters:
- SETUP_CYC, 2: sysClk cycles of address/CS setup before the strobe (t1 ≥ 70 ns at 25 MHz).
- STROBE_CYC, 5: sysClk cycles the strobe is held low (t2 ≥ 165 ns).
- HOLD_CYC, 2: sysClk cycles of CS/buffer hold after the strobe negates (recovery).
- CNT_W, 4: timer width; every *_CYC must be ≥ 1 and < 2^CNT_W.

Ports:
- sysClk  in  1  primary system clock.
- nReset  in  1  asynchronous active-low reset.
- nAS  in  1  CPU address strobe.
- RnW  in  1  CPU read/write (1 = read).
- ideSel  in  1  decoded IDE region hit (active-high, combinational from address/FC).
- regBank  in  1  0 = command block (CS1), 1 = control block (CS3).
- nIdeIO16  in  1  drive IOCS16 (active-low = 16-bit port).
- nIdeCE  out  1  IDE enable, active-low.
- nIdeCS1  out  1  command-block chip select, active-low.
- nIdeCS3  out  1  control-block chip select, active-low.
- nIORd  out  1  IDE read strobe, active-low.
- nIOWr  out  1  IDE write strobe, active-low.
- nIdeBufEn  out  1  data buffer enable, active-low.
- znDsack  inout  2  open-drain DSACK[1:0]; driven 0 or released Z.

Behaviour:
- Reset, asynchronous: state IDLE; all active-low outputs 1; znDsack = ZZ; timer = 0.
- All state registered on posedge sysClk; outputs are registered decodes of state (no glitches).
- Inputs nAS, ideSel and nIdeIO16 pass through a 1-flop synchroniser before use. Effective nAS-to-CE latency is 2 clocks.
- IDLE:
  - Start when synced nAS = 0 and ideSel = 1.
  - Latch RnW and regBank into dir/bank registers; load timer with SETUP_CYC-1; go to SETUP.
- SETUP:
  - nIdeCE = 0; CS1 or CS3 = 0 per bank; nIdeBufEn = 0.
  - When timer = 0, load STROBE_CYC-1 and go to STROBE.
- STROBE:
  - As SETUP, plus nIORd = 0 if read, or nIOWr = 0 if write.
  - When timer = 0, sample synced nIdeIO16, load HOLD_CYC-1, go to ACK.
- ACK:
  - Strobe negated; CE/CS/BufEn held.
  - Assert znDsack: 2'b01 (DSACK1 only) if sampled IO16 = 0, else 2'b10 (DSACK0 only).
  - Read data stays valid through the buffer during hold.
  - When timer = 0, go to WAIT_AS.
- WAIT_AS:
  - CE/CS/BufEn negated; DSACK still driven.
  - When synced nAS = 1, release znDsack to ZZ and go to IDLE.
- Abort: if synced nAS = 1 in SETUP or STROBE, negate the strobe next clock, go to ACK with DSACK suppressed, and still honour HOLD_CYC.
- nAS held low in IDLE with ideSel = 0: no response.
- Back-to-back cycles: a new cycle cannot start until IDLE is re-entered. Minimum IDLE dwell is 1 clock.
- Reset mid-cycle: all outputs return to reset values asynchronously; no partial DSACK is left driven.
- The timer is a down-counter and never wraps; a load occurs only on a state entry.

Optional Feature:
- Macro: MEZ_IDE_IORDY_EN.
- When defined:
  - Adds input nIdeIordy (1 = ready, active-low not-ready) and inout znBerr (open-drain).
  - Parameter IORDY_TMO (default 250 clocks, 10 µs).
  - In STROBE at timer = 0, a synced nIdeIordy = 0 extends the strobe while counting IORDY_TMO.
  - On timeout, negate the strobe and drive znBerr = 0 in place of DSACK until nAS = 1.
- When undefined: no extra ports, and IORDY is ignored.

Decomposition:
- Package mez_pkg holds:
  - the ide_state_t enum {IDLE, SETUP, STROBE, ACK, WAIT_AS};
  - constants DSACK_16 = 2'b01, DSACK_8 = 2'b10, DSACK_NONE;
  - default timing constants.
- Sub-module mez_cycle_timer: loadable CNT_W down-counter with load, value and zero outputs. It is reused for the IORDY timeout.

Test Plan:
- Read, CS1, IO16 = 0, default params: nIdeCE low 2 clocks after nAS; nIORd low exactly 5 clocks; znDsack = 01 for 2 clocks, then held until nAS rises; then ZZ.
- Write, CS3, IO16 = 1: nIOWr low 5 clocks, nIdeCS3 low, nIdeCS1 high throughout; znDsack = 10.
- Abort: nAS negated at STROBE clock 2 → nIOWr high next clock, no DSACK ever driven, return to IDLE after 2 hold clocks.
- ideSel = 0 with nAS low 20 clocks → all outputs stay inactive, znDsack = ZZ.
- nReset asserted mid-STROBE → nIORd, nIdeCE and nIdeBufEn high immediately (asynchronous), znDsack = ZZ; next cycle runs normally.
- MEZ_IDE_IORDY_EN, nIdeIordy held 0 → strobe extends 250 clocks, then znBerr = 0 and DSACK never driven. Releasing nIdeIordy after 10 clocks → normal DSACK.

Source files
------------

// File: rtl/mez_pkg.sv
// Shared types and constants for the Mezzanine IDE PIO cycle sequencer.
package mez_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        ACK,
        WAIT_AS
    } ide_state_t;

    // DSACK[1:0] patterns, active-low: a 0 bit is driven low, a 1 bit is released.
    localparam logic [1:0] DSACK_16   = 2'b01;
    localparam logic [1:0] DSACK_8    = 2'b10;
    localparam logic [1:0] DSACK_NONE = 2'b11;

    // PIO mode 0 timing at 25 MHz.
    localparam int SETUP_CYC_DEF  = 2;
    localparam int STROBE_CYC_DEF = 5;
    localparam int HOLD_CYC_DEF   = 2;
    localparam int CNT_W_DEF      = 4;
    localparam int IORDY_TMO_DEF  = 250;

endpackage

// File: rtl/mez_cycle_timer.sv
// Loadable down-counter that stops at zero; used for phase timing and the IORDY timeout.
module mez_cycle_timer #(
    parameter int CNT_W = 4
) (
    input  logic             sysClk,
    input  logic             nReset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Load has priority; otherwise count down and hold at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - ONE;
        end
    end

    // Counter register.
    always_ff @(posedge sysClk or negedge nReset) begin
        if (!nReset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/mez_ide_cycle.sv
// IDE PIO bus-cycle sequencer: turns a 68030 bus cycle into timed ATA chip selects,
// IORD/IOWR strobes and buffer enable, and terminates it with a sized DSACK.
// Optional: define MEZ_IDE_IORDY_EN to add IORDY strobe extension with a bus-error timeout.
module mez_ide_cycle
    import mez_pkg::*;
#(
    parameter int SETUP_CYC  = SETUP_CYC_DEF,
    parameter int STROBE_CYC = STROBE_CYC_DEF,
    parameter int HOLD_CYC   = HOLD_CYC_DEF,
    parameter int CNT_W      = CNT_W_DEF
`ifdef MEZ_IDE_IORDY_EN
    ,
    parameter int IORDY_TMO  = IORDY_TMO_DEF
`endif
) (
    input  logic       sysClk,
    input  logic       nReset,
    input  logic       nAS,
    input  logic       RnW,
    input  logic       ideSel,
    input  logic       regBank,
    input  logic       nIdeIO16,
    output logic       nIdeCE,
    output logic       nIdeCS1,
    output logic       nIdeCS3,
    output logic       nIORd,
    output logic       nIOWr,
    output logic       nIdeBufEn,
    inout  wire  [1:0] znDsack
`ifdef MEZ_IDE_IORDY_EN
    ,
    input  logic       nIdeIordy,
    inout  wire        znBerr
`endif
);

    localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);

    ide_state_t state_q, state_d;
    logic       nas_s_q, sel_s_q, io16_s_q;
    logic       dir_q, dir_d;
    logic       bank_q, bank_d;
    logic [1:0] ack_q, ack_d;
    logic       tmr_load;
    logic [CNT_W-1:0] tmr_ld_val;
    logic       tmr_zero;
    logic       active, strobe, acking;
    logic       ce_q, ce_d, cs1_q, cs1_d, cs3_q, cs3_d;
    logic       rd_q, rd_d, wr_q, wr_d, buf_q, buf_d;
    logic [1:0] dsack_q, dsack_d;

`ifdef MEZ_IDE_IORDY_EN
    localparam int TMO_W = (IORDY_TMO > 1) ? $clog2(IORDY_TMO) : 1;
    localparam logic [TMO_W-1:0] TMO_LD = TMO_W'(IORDY_TMO - 1);

    logic iordy_s_q;
    logic tmo_load, tmo_dec, tmo_zero;
    logic berr_flag_q, berr_flag_d;
    logic berr_q, berr_d;

    mez_cycle_timer #(.CNT_W(TMO_W)) u_tmo (
        .sysClk   (sysClk),
        .nReset   (nReset),
        .load     (tmo_load),
        .load_val (TMO_LD),
        .dec      (tmo_dec),
        .zero     (tmo_zero)
    );
`endif

    mez_cycle_timer #(.CNT_W(CNT_W)) u_tmr (
        .sysClk   (sysClk),
        .nReset   (nReset),
        .load     (tmr_load),
        .load_val (tmr_ld_val),
        .dec      (1'b1),
        .zero     (tmr_zero)
    );

    // Single-flop synchronisers for the asynchronous bus inputs.
    always_ff @(posedge sysClk or negedge nReset) begin
        if (!nReset) begin
            nas_s_q  <= 1'b1;
            sel_s_q  <= 1'b0;
            io16_s_q <= 1'b1;
`ifdef MEZ_IDE_IORDY_EN
            iordy_s_q <= 1'b1;
`endif
        end else begin
            nas_s_q  <= nAS;
            sel_s_q  <= ideSel;
            io16_s_q <= nIdeIO16;
`ifdef MEZ_IDE_IORDY_EN
            iordy_s_q <= nIdeIordy;
`endif
        end
    end

    // Next state, direction/bank/ack latches and timer loads (loads only on state entry).
    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        bank_d     = bank_q;
        ack_d      = ack_q;
        tmr_load   = 1'b0;
        tmr_ld_val = SETUP_LD;
`ifdef MEZ_IDE_IORDY_EN
        berr_flag_d = berr_flag_q;
        tmo_load    = 1'b0;
        tmo_dec     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (!nas_s_q && sel_s_q) begin
                    state_d    = SETUP;
                    dir_d      = RnW;
                    bank_d     = regBank;
                    ack_d      = DSACK_NONE;
                    tmr_load   = 1'b1;
                    tmr_ld_val = SETUP_LD;
`ifdef MEZ_IDE_IORDY_EN
                    berr_flag_d = 1'b0;
`endif
                end
            end
            SETUP: begin
                if (nas_s_q) begin
                    // CPU abandoned the cycle: hold phase without acknowledge.
                    state_d    = ACK;
                    ack_d      = DSACK_NONE;
                    tmr_load   = 1'b1;
                    tmr_ld_val = HOLD_LD;
                end else if (tmr_zero) begin
                    state_d    = STROBE;
                    tmr_load   = 1'b1;
                    tmr_ld_val = STROBE_LD;
`ifdef MEZ_IDE_IORDY_EN
                    tmo_load   = 1'b1;
`endif
                end
            end
            STROBE: begin
                if (nas_s_q) begin
                    state_d    = ACK;
                    ack_d      = DSACK_NONE;
                    tmr_load   = 1'b1;
                    tmr_ld_val = HOLD_LD;
                end else if (tmr_zero) begin
                    state_d    = ACK;
                    ack_d      = io16_s_q ? DSACK_8 : DSACK_16;
                    tmr_load   = 1'b1;
                    tmr_ld_val = HOLD_LD;
`ifdef MEZ_IDE_IORDY_EN
                    if (!iordy_s_q) begin
                        if (!tmo_zero) begin
                            // Drive not ready: keep the strobe asserted and run the timeout.
                            state_d  = STROBE;
                            ack_d    = ack_q;
                            tmr_load = 1'b0;
                            tmo_dec  = 1'b1;
                        end else begin
                            ack_d       = DSACK_NONE;
                            berr_flag_d = 1'b1;
                        end
                    end
`endif
                end
            end
            ACK: begin
                if (tmr_zero) begin
                    state_d = WAIT_AS;
                end
            end
            WAIT_AS: begin
                if (nas_s_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output levels decoded from the next state so the pins come straight from flops.
    always_comb begin
        active  = (state_d == SETUP) || (state_d == STROBE) || (state_d == ACK);
        strobe  = (state_d == STROBE);
        acking  = (state_d == ACK) || (state_d == WAIT_AS);
        ce_d    = ~active;
        cs1_d   = ~(active & ~bank_d);
        cs3_d   = ~(active & bank_d);
        rd_d    = ~(strobe & dir_d);
        wr_d    = ~(strobe & ~dir_d);
        buf_d   = ~active;
        dsack_d = acking ? ack_d : DSACK_NONE;
`ifdef MEZ_IDE_IORDY_EN
        berr_d  = ~(acking & berr_flag_d);
`endif
    end

    // State, latches and registered outputs; reset forces every output inactive at once.
    always_ff @(posedge sysClk or negedge nReset) begin
        if (!nReset) begin
            state_q <= IDLE;
            dir_q   <= 1'b1;
            bank_q  <= 1'b0;
            ack_q   <= DSACK_NONE;
            ce_q    <= 1'b1;
            cs1_q   <= 1'b1;
            cs3_q   <= 1'b1;
            rd_q    <= 1'b1;
            wr_q    <= 1'b1;
            buf_q   <= 1'b1;
            dsack_q <= DSACK_NONE;
`ifdef MEZ_IDE_IORDY_EN
            berr_flag_q <= 1'b0;
            berr_q      <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            bank_q  <= bank_d;
            ack_q   <= ack_d;
            ce_q    <= ce_d;
            cs1_q   <= cs1_d;
            cs3_q   <= cs3_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            buf_q   <= buf_d;
            dsack_q <= dsack_d;
`ifdef MEZ_IDE_IORDY_EN
            berr_flag_q <= berr_flag_d;
            berr_q      <= berr_d;
`endif
        end
    end

    assign nIdeCE     = ce_q;
    assign nIdeCS1    = cs1_q;
    assign nIdeCS3    = cs3_q;
    assign nIORd      = rd_q;
    assign nIOWr      = wr_q;
    assign nIdeBufEn  = buf_q;
    assign znDsack[0] = dsack_q[0] ? 1'bz : 1'b0;
    assign znDsack[1] = dsack_q[1] ? 1'bz : 1'b0;
`ifdef MEZ_IDE_IORDY_EN
    assign znBerr     = berr_q ? 1'bz : 1'b0;
`endif

endmodule

// File: tb/tb_mez_ide_cycle.sv
// Bench for mez_ide_cycle: directed and randomized bus cycles compared cycle by cycle
// against an interval-based reference of the expected pin waveform.
`timescale 1ns/1ps
module tb_mez_ide_cycle;

    localparam int S = 2;
    localparam int T = 5;
    localparam int H = 2;

    logic sysClk   = 1'b0;
    logic nReset   = 1'b0;
    logic nAS      = 1'b1;
    logic RnW      = 1'b1;
    logic ideSel   = 1'b0;
    logic regBank  = 1'b0;
    logic nIdeIO16 = 1'b1;
    logic nIdeCE, nIdeCS1, nIdeCS3, nIORd, nIOWr, nIdeBufEn;
    tri1 [1:0] znDsack;
    logic [7:0] outs;

    int n_tests = 0;
    int n_fail  = 0;

    always #20 sysClk = ~sysClk;

    mez_ide_cycle #(
        .SETUP_CYC  (S),
        .STROBE_CYC (T),
        .HOLD_CYC   (H),
        .CNT_W      (4)
    ) dut (
        .sysClk    (sysClk),
        .nReset    (nReset),
        .nAS       (nAS),
        .RnW       (RnW),
        .ideSel    (ideSel),
        .regBank   (regBank),
        .nIdeIO16  (nIdeIO16),
        .nIdeCE    (nIdeCE),
        .nIdeCS1   (nIdeCS1),
        .nIdeCS3   (nIdeCS3),
        .nIORd     (nIORd),
        .nIOWr     (nIOWr),
        .nIdeBufEn (nIdeBufEn),
        .znDsack   (znDsack)
    );

    assign outs = {nIdeCE, nIdeCS1, nIdeCS3, nIORd, nIOWr, nIdeBufEn, znDsack};

    task automatic check_out(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got {CE,CS1,CS3,RD,WR,BUF,DSACK}=%b expected %b",
                     tag, $time, got, exp);
        end
    endtask

    // Expected pins after the n-th clock edge following nAS falling, for a cycle whose
    // nAS is released after edge r. Two clocks of input latency, then S setup, T strobe,
    // H hold; a release seen during setup/strobe aborts without acknowledge.
    function automatic logic [7:0] model(input bit rd, input bit bank, input bit io16,
                                         input bit sel, input int r, input int n);
        bit act = 1'b0;
        bit stb = 1'b0;
        logic [1:0] ds = 2'b11;
        int ds_end;
        if (sel) begin
            if (r <= S + T) begin
                act = (n >= 2) && (n <= r + 1 + H);
                stb = (n >= 2 + S) && (n <= r + 1) && (n <= 1 + S + T);
            end else begin
                act = (n >= 2) && (n <= 1 + S + T + H);
                stb = (n >= 2 + S) && (n <= 1 + S + T);
                ds_end = (r + 1 > 2 + S + T + H) ? r + 1 : 2 + S + T + H;
                if ((n >= 2 + S + T) && (n <= ds_end))
                    ds = io16 ? 2'b10 : 2'b01;
            end
        end
        return {~act, ~(act & ~bank), ~(act & bank), ~(stb & rd), ~(stb & ~rd), ~act, ds};
    endfunction

    task automatic run_txn(input string tag, input bit rd, input bit bank, input bit io16,
                           input bit sel, input int r);
        int len;
        len = ((r > 2 + S + T + H) ? r : 2 + S + T + H) + 5;
        @(posedge sysClk); #1;
        RnW = rd; regBank = bank; nIdeIO16 = io16; ideSel = sel; nAS = 1'b0;
        for (int n = 1; n <= len; n++) begin
            @(posedge sysClk); #1;
            if (n == r) nAS = 1'b1;
            @(negedge sysClk);
            check_out(tag, outs, model(rd, bank, io16, sel, r, n));
        end
    endtask

    task automatic reset_mid_strobe();
        @(posedge sysClk); #1;
        RnW = 1'b1; regBank = 1'b0; nIdeIO16 = 1'b0; ideSel = 1'b1; nAS = 1'b0;
        for (int n = 1; n <= 6; n++) begin
            @(posedge sysClk); #1;
        end
        check_out("pre_rst", outs, model(1'b1, 1'b0, 1'b0, 1'b1, 100, 6));
        @(negedge sysClk); #3;
        nReset = 1'b0;
        #1;
        check_out("rst_async", outs, 8'hFF);
        nAS = 1'b1;
        @(posedge sysClk); #1;
        nReset = 1'b1;
        repeat (3) @(posedge sysClk);
        @(negedge sysClk);
        check_out("rst_idle", outs, 8'hFF);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit rd, bank, io16, sel;
        int r;
        nReset = 1'b0;
        repeat (2) @(posedge sysClk);
        @(negedge sysClk);
        check_out("reset", outs, 8'hFF);
        @(posedge sysClk); #1;
        nReset = 1'b1;
        repeat (2) @(negedge sysClk);
        check_out("post_reset", outs, 8'hFF);

        run_txn("rd_cs1_io16", 1'b1, 1'b0, 1'b0, 1'b1, 12);
        run_txn("wr_cs3_8bit", 1'b0, 1'b1, 1'b1, 1'b1, 12);
        run_txn("abort_strobe", 1'b0, 1'b0, 1'b0, 1'b1, 5);
        run_txn("abort_setup", 1'b1, 1'b1, 1'b0, 1'b1, 1);
        run_txn("abort_last", 1'b1, 1'b0, 1'b1, 1'b1, S + T);
        run_txn("ack_release", 1'b1, 1'b0, 1'b0, 1'b1, S + T + 1);
        run_txn("no_select", 1'b1, 1'b0, 1'b0, 1'b0, 20);
        reset_mid_strobe();
        run_txn("after_reset", 1'b1, 1'b0, 1'b0, 1'b1, 13);
        run_txn("back_to_back", 1'b0, 1'b0, 1'b1, 1'b1, 11);

        for (int i = 0; i < 40; i++) begin
            rd   = 1'($urandom_range(0, 1));
            bank = 1'($urandom_range(0, 1));
            io16 = 1'($urandom_range(0, 1));
            sel  = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 3) == 0)
                r = int'($urandom_range(1, S + T));
            else
                r = int'($urandom_range(S + T + 1, S + T + H + 8));
            run_txn("random", rd, bank, io16, sel, r);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
